// File: rtl/report_hex_stream.sv
// report_hex_stream
//   Periodic / on-demand ASCII report generator. Each line snapshots NUM_FIELDS
//   words of FIELD_WIDTH bits and streams them as uppercase hex digits,
//   space-separated, terminated by CR LF, over a valid/require byte handshake.
//
//   Optional feature macro: REPORT_HEX_SEQ_EN
//     defined   : each line is prefixed by a SEQ_WIDTH/4-digit sequence number
//                 and a space.
//     undefined : no sequence prefix; the sequence counter is not built.
//
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   enable    in   period counter run enable (low: counter held at 0, no ticks)
//   trigger   in   level-sampled manual report request
//   fields    in   NUM_FIELDS*FIELD_WIDTH, field i at [i*FIELD_WIDTH +: FIELD_WIDTH]
//   data      out  current ASCII byte (0x00 when idle)
//   valid     out  data is valid
//   require   in   consumer accepts data; transfer on valid && require
//   busy      out  a line is in progress (same as valid)
//   drop_cnt  out  saturating count of requests lost to overrun
module report_hex_stream #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int REPORT_FREQ = 2,
    parameter int NUM_FIELDS  = 4,
    parameter int FIELD_WIDTH = 32,
    parameter int SEQ_WIDTH   = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              trigger,
    input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] fields,
    output logic [7:0]                        data,
    output logic                              valid,
    input  logic                              require,
    output logic                              busy,
    output logic [7:0]                        drop_cnt
);

    localparam int REPORT_COUNT = CLK_FREQ / REPORT_FREQ;
    localparam int CNT_W        = $clog2(REPORT_COUNT);
    localparam int SEQ_DIG      = SEQ_WIDTH / 4;
    localparam int FLD_DIG      = FIELD_WIDTH / 4;
    localparam int NIB_MAX      = (SEQ_DIG > FLD_DIG) ? SEQ_DIG : FLD_DIG;
    localparam int NIB_W        = (NIB_MAX > 1) ? $clog2(NIB_MAX) : 1;
    localparam int FLD_W        = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REPORT_COUNT - 1);
    localparam logic [NIB_W-1:0] FLD_LAST   = NIB_W'(FLD_DIG - 1);
    localparam logic [FLD_W-1:0] LAST_FIELD = FLD_W'(NUM_FIELDS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SP    = 3'd2;
    localparam logic [2:0] ST_FIELD = 3'd3;
    localparam logic [2:0] ST_CR    = 3'd4;
    localparam logic [2:0] ST_LF    = 3'd5;
`ifdef REPORT_HEX_SEQ_EN
    localparam logic [2:0] ST_SEQ   = 3'd1;
    localparam logic [NIB_W-1:0] SEQ_LAST = NIB_W'(SEQ_DIG - 1);
    localparam logic [2:0] ST_FIRST = ST_SEQ;
`else
    localparam logic [2:0] ST_FIRST = ST_FIELD;
`endif

    logic [2:0]             state;
    logic [NIB_W-1:0]       nib_idx;
    logic [FLD_W-1:0]       fld_idx;
    logic [FIELD_WIDTH-1:0] snap [NUM_FIELDS];
    logic [CNT_W-1:0]       period_cnt;
    logic                   pending;
`ifdef REPORT_HEX_SEQ_EN
    logic [SEQ_WIDTH-1:0]   seq_cnt;
    logic [SEQ_WIDTH-1:0]   seq_snap;
`endif

    logic tick, req, xfer, lf_done, start, overrun;

    assign tick    = enable && (period_cnt == CNT_LAST);
    assign req     = tick || trigger;
    assign xfer    = valid && require;
    assign lf_done = xfer && (state == ST_LF);
    // A request landing on the LF transfer cycle is folded into the restart
    // rather than parked in pending, so it can never be stranded in IDLE.
    assign start   = ((state == ST_IDLE) && req) || (lf_done && (pending || req));
    assign overrun = valid && req && pending && !lf_done;

    assign valid = (state != ST_IDLE);
    assign busy  = valid;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // Output byte: digits are picked MSB nibble first by shifting the
    // selected word right by (last - index) nibbles.
    logic [NIB_W-1:0]       fld_rev;
    logic [FIELD_WIDTH-1:0] fld_sh;
    assign fld_rev = FLD_LAST - nib_idx;
    assign fld_sh  = snap[fld_idx] >> {fld_rev, 2'b00};
`ifdef REPORT_HEX_SEQ_EN
    logic [NIB_W-1:0]       seq_rev;
    logic [SEQ_WIDTH-1:0]   seq_sh;
    assign seq_rev = SEQ_LAST - nib_idx;
    assign seq_sh  = seq_snap >> {seq_rev, 2'b00};
`endif

    always_comb begin
        data = 8'h00;
        case (state)
`ifdef REPORT_HEX_SEQ_EN
            ST_SEQ:   data = hex_char(seq_sh[3:0]);
`endif
            ST_SP:    data = 8'h20;
            ST_FIELD: data = hex_char(fld_sh[3:0]);
            ST_CR:    data = 8'h0D;
            ST_LF:    data = 8'h0A;
            default:  data = 8'h00;
        endcase
    end

    // Period counter keeps running while a line is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= '0;
        else if (!enable || period_cnt == CNT_LAST)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 1'b1;
    end

    // Request bookkeeping: one-deep pending, saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (!valid)
                pending <= 1'b0;
            else if (lf_done)
                pending <= pending && req;
            else if (req)
                pending <= 1'b1;
            if (overrun && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'h01;
        end
    end

    // Line sequencer and snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            nib_idx <= '0;
            fld_idx <= '0;
            for (int i = 0; i < NUM_FIELDS; i++)
                snap[i] <= '0;
`ifdef REPORT_HEX_SEQ_EN
            seq_cnt  <= '0;
            seq_snap <= '0;
`endif
        end else if (start) begin
            state   <= ST_FIRST;
            nib_idx <= '0;
            fld_idx <= '0;
            for (int i = 0; i < NUM_FIELDS; i++)
                snap[i] <= fields[i*FIELD_WIDTH +: FIELD_WIDTH];
`ifdef REPORT_HEX_SEQ_EN
            seq_snap <= seq_cnt;
            seq_cnt  <= seq_cnt + 1'b1;
`endif
        end else if (xfer) begin
            case (state)
`ifdef REPORT_HEX_SEQ_EN
                ST_SEQ: begin
                    if (nib_idx == SEQ_LAST) begin
                        nib_idx <= '0;
                        state   <= ST_SP;
                    end else begin
                        nib_idx <= nib_idx + 1'b1;
                    end
                end
`endif
                // fld_idx already points at the next field when we get here.
                ST_SP: state <= ST_FIELD;
                ST_FIELD: begin
                    if (nib_idx == FLD_LAST) begin
                        nib_idx <= '0;
                        if (fld_idx == LAST_FIELD) begin
                            state <= ST_CR;
                        end else begin
                            fld_idx <= fld_idx + 1'b1;
                            state   <= ST_SP;
                        end
                    end else begin
                        nib_idx <= nib_idx + 1'b1;
                    end
                end
                ST_CR:   state <= ST_LF;
                ST_LF:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_report_hex_stream.sv
module tb_report_hex_stream;

    localparam int CLK_FREQ    = 100;
    localparam int REPORT_FREQ = 1;
    localparam int RC          = CLK_FREQ / REPORT_FREQ;
    localparam int NF          = 4;
    localparam int FW          = 32;
    localparam int SW          = 12;
`ifdef REPORT_HEX_SEQ_EN
    localparam int LINE = SW/4 + 1 + NF*(FW/4) + NF - 1 + 2;
`else
    localparam int LINE = NF*(FW/4) + NF - 1 + 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              trigger;
    logic [NF*FW-1:0]  fields;
    logic [7:0]        data;
    logic              valid;
    logic              require;
    logic              busy;
    logic [7:0]        drop_cnt;

    report_hex_stream #(
        .CLK_FREQ(CLK_FREQ), .REPORT_FREQ(REPORT_FREQ),
        .NUM_FIELDS(NF), .FIELD_WIDTH(FW), .SEQ_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
        .fields(fields), .data(data), .valid(valid), .require(require),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int         vcycles  = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    bit         rand_req = 0;
    int         seq_model = 0;

    localparam logic [NF*FW-1:0] BASIC = {32'h0000_0004, 32'h0000_0003, 32'hDEAD_BEEF, 32'h1234_ABCD};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // Byte monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                assert (valid === 1'b1 && data === prev_data) else begin
                    failures++;
                    $error("FAIL stall_hold got=%h/%b exp=%h/1", data, valid, prev_data);
                end
            end
            checks++;
            assert (busy === valid) else begin
                failures++;
                $error("FAIL busy_eq_valid got=%b exp=%b", busy, valid);
            end
            if (valid === 1'b1) vcycles++;
            if (valid === 1'b1 && require === 1'b1) rx.push_back(data);
            prev_stall = (valid === 1'b1) && (require === 1'b0);
            prev_data  = data;
        end
    end

    function automatic logic [7:0] hexc(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endfunction

    // Reference line: built straight from the textual format.
    task automatic add_line(input int seq, input logic [NF*FW-1:0] f);
`ifdef REPORT_HEX_SEQ_EN
        for (int d = SW/4 - 1; d >= 0; d--) exp_q.push_back(hexc((seq >> (4*d)) & 15));
        exp_q.push_back(8'h20);
`endif
        for (int i = 0; i < NF; i++) begin
            for (int d = FW/4 - 1; d >= 0; d--)
                exp_q.push_back(hexc(int'((f >> (i*FW + 4*d)) & 'hF)));
            if (i < NF - 1) exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_lines(input string tag);
        int bad = -1;
        chk({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= rx.size() || rx[i] !== exp_q[i])) bad = i;
        chk({tag, "_first_bad_byte_idx"}, bad, -1);
    endtask

    task automatic clear_q();
        rx.delete();
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_req) require = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int bound, input string tag);
        int k = 0;
        while (rx.size() < n && k < bound) begin step(); k++; end
        chk({tag, "_byte_timeout"}, rx.size() >= n, 1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k = 0;
        while (valid && k < bound) begin step(); k++; end
        chk({tag, "_idle_timeout"}, valid, 0);
    endtask

    function automatic logic [NF*FW-1:0] rand_fields();
        logic [NF*FW-1:0] f;
        for (int i = 0; i < NF; i++) f[i*FW +: FW] = $urandom;
        return f;
    endfunction

    initial begin
        int n;
        bit prev;
        logic [NF*FW-1:0] f;

        rst = 1'b1; enable = 1'b0; trigger = 1'b0; require = 1'b1; fields = BASIC;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data, 8'h00);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        // Basic periodic lines
        step();
        enable = 1'b1;
        n = 0;
        while (!valid && n < 3*RC) begin step(); n++; end
        chk("tick_latency", n, RC);
        add_line(seq_model, BASIC); seq_model++;
        n = 0; prev = 1;
        while (!(valid && !prev) && n < 3*RC) begin prev = valid; step(); n++; end
        chk("tick_period", n, RC);
        add_line(seq_model, BASIC); seq_model++;
        wait_bytes(2*LINE, 300, "basic");
        enable = 1'b0;
        wait_idle(100, "basic");
        check_lines("basic");

        // Backpressure with random require
        clear_q();
        rand_req = 1;
        for (int r = 0; r < 3; r++) begin
            f = (r == 0) ? BASIC : rand_fields();
            fields = f;
            pulse();
            add_line(seq_model, f); seq_model++;
            wait_bytes(LINE*(r+1), 2000, "bp");
            wait_idle(100, "bp");
        end
        check_lines("backpressure");
        rand_req = 0;
        require = 1'b1;
        step();

        // Trigger while busy: back-to-back second line with fresh snapshot
        clear_q();
        vcycles = 0;
        f = rand_fields();
        fields = f;
        pulse();
        repeat (8) step();
        pulse();
        fields = '1;
        add_line(seq_model, f);  seq_model++;
        add_line(seq_model, '1); seq_model++;
        wait_bytes(2*LINE, 300, "trig_busy");
        wait_idle(100, "trig_busy");
        check_lines("trig_busy");
        chk("trig_busy_no_gap", vcycles, 2*LINE);
        chk("trig_busy_drop", drop_cnt, 0);

        // Overrun: one pending plus two dropped
        clear_q();
        require = 1'b0;
        f = rand_fields();
        fields = f;
        pulse(); step();
        pulse(); step();
        pulse(); step();
        pulse(); step();
        chk("overrun_drop", drop_cnt, 2);
        chk("overrun_stalled_valid", valid, 1);
        require = 1'b1;
        add_line(seq_model, f); seq_model++;
        add_line(seq_model, f); seq_model++;
        wait_bytes(2*LINE, 300, "overrun");
        repeat (2*LINE) step();
        chk("overrun_extra_bytes", rx.size(), 2*LINE);
        chk("overrun_idle", valid, 0);
        check_lines("overrun");

        // Saturation
        clear_q();
        require = 1'b0;
        f = rand_fields();
        fields = f;
        pulse();
        trigger = 1'b1;
        repeat (300) step();
        trigger = 1'b0;
        chk("drop_saturate", drop_cnt, 255);
        require = 1'b1;
        add_line(seq_model, f); seq_model++;
        add_line(seq_model, f); seq_model++;
        wait_bytes(2*LINE, 300, "sat");
        wait_idle(100, "sat");
        check_lines("saturate");

        // Reset mid-line
        clear_q();
        f = rand_fields();
        fields = f;
        pulse();
        wait_bytes(10, 100, "rst_mid");
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", valid, 0);
        chk("rst_mid_data", data, 8'h00);
        chk("rst_mid_drop", drop_cnt, 0);
        step(); step();
        rst = 1'b0;
        clear_q();
        seq_model = 0;
        f = rand_fields();
        fields = f;
        step();
        pulse();
        add_line(seq_model, f); seq_model++;
        wait_bytes(LINE, 200, "after_rst");
        wait_idle(100, "after_rst");
        check_lines("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
